// File: rtl/fetcher_if.sv
// fetcher_if: valid/ready read port between the instruction fetcher and program memory.
interface fetcher_if #(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 16
);
    logic                 mem_read_valid;
    logic [ADDR_BITS-1:0] mem_read_address;
    logic                 mem_read_ready;
    logic [DATA_BITS-1:0] mem_read_data;
    modport master (output mem_read_valid, mem_read_address, input mem_read_ready, mem_read_data);
    modport slave  (input mem_read_valid, mem_read_address, output mem_read_ready, mem_read_data);
endinterface

// File: rtl/fetcher.sv
// fetcher: per-core instruction fetcher issuing valid/ready reads to program memory.
// Optional one-entry reuse buffer enabled by defining FETCHER_CACHE_EN.
`ifndef CORE_FETCH
`define CORE_FETCH 3'b001
`endif
`ifndef CORE_DECODE
`define CORE_DECODE 3'b010
`endif
module fetcher #(
    parameter int PROGRAM_MEM_ADDR_BITS = 8,
    parameter int PROGRAM_MEM_DATA_BITS = 16,
    parameter int TIMEOUT_CYCLES        = 255
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             enable,
    input  logic [2:0]                       core_state,
    input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
    input  logic                             cache_flush,
    fetcher_if.master                        mem,
    output logic [2:0]                       fetcher_state,
    output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction,
    output logic                             fetch_error,
    output logic [15:0]                      fetch_count
);
    localparam logic [2:0] IDLE = 3'd0, FETCHING = 3'd1, FETCHED = 3'd2;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 2);

    logic [2:0]                       state, next;
    logic [PROGRAM_MEM_ADDR_BITS-1:0] address;
    logic [TW-1:0]                    timer;
    logic                             start, handshake, timeout, hit;
    logic [PROGRAM_MEM_DATA_BITS-1:0] cached_word;

    assign start     = state == IDLE && core_state == `CORE_FETCH;
    assign handshake = state == FETCHING && mem.mem_read_ready;
    // Ready in the timeout cycle counts as a handshake, so timeout requires ready low.
    assign timeout   = state == FETCHING && !mem.mem_read_ready && TIMEOUT_CYCLES != 0
                       && timer == TW'(TIMEOUT_CYCLES - 1);

`ifdef FETCHER_CACHE_EN
    logic [PROGRAM_MEM_ADDR_BITS-1:0] tag;
    logic                             tag_valid;
    assign hit = tag_valid && tag == current_pc && !cache_flush;
    always_ff @(posedge clk) begin
        if (reset) begin
            tag_valid <= 1'b0;
        end else if (enable) begin
            tag_valid <= (cache_flush || timeout) ? 1'b0 : handshake ? 1'b1 : tag_valid;
            if (handshake) begin
                tag         <= address;
                cached_word <= mem.mem_read_data;
            end
        end
    end
`else
    logic unused_flush;
    assign unused_flush = cache_flush;
    assign hit          = 1'b0;
    assign cached_word  = '0;
`endif

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= next;
    end

    always_comb begin
        next = state;
        if (enable)
            case (state)
                IDLE:     next = start ? (hit ? FETCHED : FETCHING) : IDLE;
                FETCHING: next = (handshake || timeout) ? FETCHED : FETCHING;
                FETCHED:  next = core_state == `CORE_DECODE ? IDLE : FETCHED;
                default:  next = IDLE;
            endcase
    end

    always_comb begin
        mem.mem_read_valid   = state == FETCHING;
        mem.mem_read_address = address;
        fetcher_state        = state;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            address     <= '0;
            instruction <= '0;
            fetch_error <= 1'b0;
            fetch_count <= '0;
            timer       <= '0;
        end else if (enable) begin
            if (start && hit) instruction <= cached_word;
            if (start && !hit) begin
                address <= current_pc;
                timer   <= '0;
            end
            if (handshake) begin
                instruction <= mem.mem_read_data;
                fetch_count <= fetch_count + 16'd1;
            end else if (timeout) begin
                instruction <= '0;
                fetch_error <= 1'b1;
            end else if (state == FETCHING) begin
                timer <= timer + TW'(1);
            end
        end
    end
endmodule

// File: tb/tb_fetcher.sv
// tb_fetcher: directed scoreboard bench for fetcher (TIMEOUT_CYCLES=4).
`ifndef CORE_FETCH
`define CORE_FETCH 3'b001
`endif
`ifndef CORE_DECODE
`define CORE_DECODE 3'b010
`endif
module tb_fetcher;
    logic        clk = 0, reset = 1, enable = 1, cache_flush = 0;
    logic [2:0]  core_state = 3'b000;
    logic [7:0]  current_pc = 0;
    logic [2:0]  fetcher_state;
    logic [15:0] instruction, fetch_count;
    logic        fetch_error;
    int          vectors = 0, miscompares = 0;
    int          exp_count = 0;
    logic [15:0] exp_q[$];

    fetcher_if #(.ADDR_BITS(8), .DATA_BITS(16)) bus ();

    fetcher #(.PROGRAM_MEM_ADDR_BITS(8), .PROGRAM_MEM_DATA_BITS(16), .TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .enable(enable), .core_state(core_state),
        .current_pc(current_pc), .cache_flush(cache_flush), .mem(bus.master),
        .fetcher_state(fetcher_state), .instruction(instruction),
        .fetch_error(fetch_error), .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pop_check(input string tag);
        logic [15:0] e;
        if (exp_q.size() == 0) begin
            check({tag, "_queue_empty"}, 1, 0);
        end else begin
            e = exp_q.pop_front();
            check(tag, instruction, e);
        end
    endtask

    task automatic wait_fetched(input string tag, input int budget);
        int n = 0;
        while (fetcher_state !== 3'd2 && n < budget) begin
            tick();
            n++;
        end
        check({tag, "_reached_fetched"}, fetcher_state, 3'd2);
    endtask

    task automatic decode_to_idle(input string tag);
        core_state = `CORE_DECODE;
        tick();
        core_state = 3'b000;
        check({tag, "_idle"}, fetcher_state, 3'd0);
    endtask

    initial begin
        bus.mem_read_ready = 0;
        bus.mem_read_data  = 0;
        tick(); tick();
        check("rst_state", fetcher_state, 0);
        check("rst_valid", bus.mem_read_valid, 0);
        check("rst_addr", bus.mem_read_address, 0);
        check("rst_instr", instruction, 0);
        check("rst_err", fetch_error, 0);
        check("rst_count", fetch_count, 0);
        reset = 0;
        tick();
        check("idle_hold", fetcher_state, 0);

        // basic read, ready three cycles after valid
        core_state = `CORE_FETCH; current_pc = 8'h05;
        tick();
        check("basic_state1", fetcher_state, 1);
        check("basic_valid", bus.mem_read_valid, 1);
        check("basic_addr", bus.mem_read_address, 8'h05);
        current_pc = 8'h77;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("basic_wait_valid", bus.mem_read_valid, 1);
            check("basic_addr_stable", bus.mem_read_address, 8'h05);
        end
        bus.mem_read_ready = 1; bus.mem_read_data = 16'h1234; exp_q.push_back(16'h1234); exp_count++;
        tick();
        bus.mem_read_ready = 0;
        check("basic_state2", fetcher_state, 2);
        check("basic_valid_low", bus.mem_read_valid, 0);
        pop_check("basic_instr");
        check("basic_count", fetch_count, exp_count);
        decode_to_idle("basic");
        check("basic_instr_held", instruction, 16'h1234);

        // back-to-back with ready held high
        bus.mem_read_ready = 1;
        for (int i = 0; i < 3; i++) begin
            core_state = `CORE_FETCH; current_pc = 8'(i);
            bus.mem_read_data = 16'hA000 + 16'(i); exp_q.push_back(16'hA000 + 16'(i)); exp_count++;
            tick();
            check("b2b_fetching", fetcher_state, 1);
            tick();
            check("b2b_fetched", fetcher_state, 2);
            check("b2b_addr", bus.mem_read_address, i);
            pop_check("b2b_instr");
            decode_to_idle("b2b");
        end
        bus.mem_read_ready = 0;
        check("b2b_count", fetch_count, exp_count);

        // ready on the cycle the timeout would fire: handshake wins
        core_state = `CORE_FETCH; current_pc = 8'h20;
        tick();
        core_state = 3'b000;
        tick(); tick(); tick();
        check("edge_still_valid", bus.mem_read_valid, 1);
        bus.mem_read_ready = 1; bus.mem_read_data = 16'h0F0F; exp_q.push_back(16'h0F0F); exp_count++;
        tick();
        bus.mem_read_ready = 0;
        check("edge_state", fetcher_state, 2);
        pop_check("edge_instr");
        check("edge_no_err", fetch_error, 0);
        check("edge_count", fetch_count, exp_count);
        decode_to_idle("edge");

        // timeout with ready never asserted
        core_state = `CORE_FETCH; current_pc = 8'h30;
        tick();
        core_state = 3'b000;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("to_valid_held", bus.mem_read_valid, 1);
        end
        exp_q.push_back(16'h0000);
        tick();
        check("to_valid_drop", bus.mem_read_valid, 0);
        check("to_state", fetcher_state, 2);
        pop_check("to_instr");
        check("to_err", fetch_error, 1);
        check("to_count", fetch_count, exp_count);
        decode_to_idle("to");

        // enable stall while ready is high
        core_state = `CORE_FETCH; current_pc = 8'h40;
        tick();
        core_state = 3'b000;
        enable = 0; bus.mem_read_ready = 1; bus.mem_read_data = 16'hBEEF;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_valid", bus.mem_read_valid, 1);
            check("stall_state", fetcher_state, 1);
        end
        check("stall_no_capture", instruction, 0);
        check("stall_count", fetch_count, exp_count);
        enable = 1; exp_q.push_back(16'hBEEF); exp_count++;
        tick();
        bus.mem_read_ready = 0;
        check("stall_state2", fetcher_state, 2);
        pop_check("stall_instr");
        check("stall_count2", fetch_count, exp_count);
        check("err_sticky", fetch_error, 1);
        decode_to_idle("stall");

        // reset mid-wait
        reset = 1; tick(); reset = 0; exp_count = 0;
        check("rst2_err", fetch_error, 0);
        core_state = `CORE_FETCH; current_pc = 8'h50;
        tick();
        core_state = 3'b000;
        check("rmw_valid", bus.mem_read_valid, 1);
        reset = 1; bus.mem_read_ready = 1; bus.mem_read_data = 16'hDEAD;
        tick();
        reset = 0; bus.mem_read_ready = 0;
        check("rmw_valid_drop", bus.mem_read_valid, 0);
        check("rmw_state", fetcher_state, 0);
        check("rmw_instr", instruction, 0);
        check("rmw_count", fetch_count, 0);

        // reuse buffer
        core_state = `CORE_FETCH; current_pc = 8'h10;
        bus.mem_read_ready = 1; bus.mem_read_data = 16'h5A5A; exp_q.push_back(16'h5A5A); exp_count++;
        tick();
        wait_fetched("c1", 10);
        bus.mem_read_ready = 0;
        pop_check("c1_instr");
        decode_to_idle("c1");
        core_state = `CORE_FETCH;
        tick();
`ifdef FETCHER_CACHE_EN
        exp_q.push_back(16'h5A5A);
        check("c2_hit_state", fetcher_state, 2);
        check("c2_no_valid", bus.mem_read_valid, 0);
        pop_check("c2_instr");
        check("c2_count", fetch_count, exp_count);
        decode_to_idle("c2");
        cache_flush = 1; tick(); cache_flush = 0;
        core_state = `CORE_FETCH;
        tick();
        check("c3_refetch_valid", bus.mem_read_valid, 1);
`else
        check("c2_request", bus.mem_read_valid, 1);
        check("c2_state", fetcher_state, 1);
`endif
        core_state = 3'b000;
        bus.mem_read_ready = 1; bus.mem_read_data = 16'h5A5B; exp_q.push_back(16'h5A5B); exp_count++;
        tick();
        bus.mem_read_ready = 0;
        wait_fetched("c3", 10);
        pop_check("c3_instr");
        check("c3_count", fetch_count, exp_count);
        decode_to_idle("c3");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end
endmodule
